// File: rtl/ula_mul_seq.sv
// ula_mul_seq
// ------------------------------------------------------------------------
// Multi-cycle unsigned shift-and-add multiplier that borrows the shared ULA.
// It sits between the control unit and the ULA and owns the ULA inputs
// while a multiplication is in progress. It returns the low word of the
// product together with overflow and zero flags.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset (aborts any operation)
//   inicio         start request, sampled only while idle
//   multiplicando  operand X, captured when inicio is accepted
//   multiplicador  operand Y, captured when inicio is accepted
//   ocupado        high while iterating (SOMA / DESLOCA)
//   pronto         one-cycle completion strobe (FIM)
//   produto        low word of X*Y, held until the next completion
//   flag_overflow  true product did not fit in bits_palavra bits
//   flag_zero      produto == 0
//   ula_controle   ULA opcode
//   ula_operandoA  ULA operand A
//   ula_operandoB  ULA operand B
//   ula_resultado  ULA result
//   ula_C          ULA carry flag
//
// Timing: inicio accepted at edge T; SOMA/DESLOCA fill cycles T+1..T+32
// and FIM (pronto) falls in cycle T+33. There is no early exit.
// ------------------------------------------------------------------------
module ula_mul_seq #(
    parameter int bits_palavra = 16,
    parameter int iteracoes    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inicio,
    input  logic [bits_palavra-1:0] multiplicando,
    input  logic [bits_palavra-1:0] multiplicador,
    output logic                    ocupado,
    output logic                    pronto,
    output logic [bits_palavra-1:0] produto,
    output logic                    flag_overflow,
    output logic                    flag_zero,
    output logic [4:0]              ula_controle,
    output logic [bits_palavra-1:0] ula_operandoA,
    output logic [bits_palavra-1:0] ula_operandoB,
    input  logic [bits_palavra-1:0] ula_resultado,
    input  logic                    ula_C
);

    localparam int cnt_w = (iteracoes > 1) ? $clog2(iteracoes) : 1;
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(iteracoes - 1);

    // ULA opcodes used by the sequencer
    localparam logic [4:0] op_add   = 5'b00000;
    localparam logic [4:0] op_shl   = 5'b01000;
    localparam logic [4:0] op_idle  = 5'b10000;
    localparam logic [4:0] op_passa = 5'b10101;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        SOMA    = 2'd1,
        DESLOCA = 2'd2,
        FIM     = 2'd3
    } estado_t;

    estado_t                 state_reg, state_next;
    logic [bits_palavra-1:0] acc_reg;
    logic [bits_palavra-1:0] mcand_reg;
    logic [bits_palavra-1:0] mult_reg;
    logic [cnt_w-1:0]        cnt_reg;
    logic                    sticky_reg;
    logic [bits_palavra-1:0] produto_reg;
    logic                    flag_overflow_reg;
    logic                    flag_zero_reg;

    // Multiplier with the bit just consumed removed; non-zero means more
    // partial products are still to be added.
    logic [bits_palavra-1:0] mult_shift;
    assign mult_shift = mult_reg >> 1;

    // Next state, status outputs and ULA drive
    always_comb begin
        state_next    = state_reg;
        ocupado       = 1'b0;
        pronto        = 1'b0;
        ula_controle  = op_idle;
        ula_operandoA = '0;
        ula_operandoB = '0;
        case (state_reg)
            OCIOSO: begin
                if (inicio) state_next = SOMA;
            end
            SOMA: begin
                ocupado       = 1'b1;
                // A zero multiplier bit still spends the cycle (pass A),
                // keeping the latency independent of the operands.
                ula_controle  = mult_reg[0] ? op_add : op_passa;
                ula_operandoA = acc_reg;
                ula_operandoB = mcand_reg;
                state_next    = DESLOCA;
            end
            DESLOCA: begin
                ocupado       = 1'b1;
                ula_controle  = op_shl;
                ula_operandoA = mcand_reg;
                state_next    = (cnt_reg == cnt_last) ? FIM : SOMA;
            end
            FIM: begin
                pronto     = 1'b1;
                state_next = OCIOSO;
            end
            default: state_next = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= OCIOSO;
            acc_reg           <= '0;
            mcand_reg         <= '0;
            mult_reg          <= '0;
            cnt_reg           <= '0;
            sticky_reg        <= 1'b0;
            produto_reg       <= '0;
            flag_overflow_reg <= 1'b0;
            flag_zero_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                OCIOSO: begin
                    if (inicio) begin
                        acc_reg    <= '0;
                        mcand_reg  <= multiplicando;
                        mult_reg   <= multiplicador;
                        cnt_reg    <= '0;
                        sticky_reg <= 1'b0;
                    end
                end
                SOMA: begin
                    acc_reg <= ula_resultado;
                    if (mult_reg[0] && ula_C) sticky_reg <= 1'b1;
                end
                DESLOCA: begin
                    mcand_reg <= ula_resultado;
                    // A bit shifted out of the multiplicand only overflows
                    // the product if a higher multiplier bit will add it.
                    if (ula_C && (mult_shift != '0)) sticky_reg <= 1'b1;
                    mult_reg <= mult_shift;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == cnt_last) begin
                        // The final DESLOCA never changes acc, and with no
                        // multiplier bits left it cannot set sticky either.
                        produto_reg       <= acc_reg;
                        flag_zero_reg     <= (acc_reg == '0);
                        flag_overflow_reg <= sticky_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign produto       = produto_reg;
    assign flag_overflow = flag_overflow_reg;
    assign flag_zero     = flag_zero_reg;

endmodule

// File: tb/tb_ula_mul_seq.sv
module tb_ula_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        inicio;
    logic [15:0] multiplicando;
    logic [15:0] multiplicador;
    logic        ocupado;
    logic        pronto;
    logic [15:0] produto;
    logic        flag_overflow;
    logic        flag_zero;
    logic [4:0]  ula_controle;
    logic [15:0] ula_operandoA;
    logic [15:0] ula_operandoB;
    logic [15:0] ula_resultado;
    logic        ula_C;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ula_mul_seq #(.bits_palavra(16), .iteracoes(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .inicio        (inicio),
        .multiplicando (multiplicando),
        .multiplicador (multiplicador),
        .ocupado       (ocupado),
        .pronto        (pronto),
        .produto       (produto),
        .flag_overflow (flag_overflow),
        .flag_zero     (flag_zero),
        .ula_controle  (ula_controle),
        .ula_operandoA (ula_operandoA),
        .ula_operandoB (ula_operandoB),
        .ula_resultado (ula_resultado),
        .ula_C         (ula_C)
    );

    // Behavioural ULA: only the opcodes the sequencer uses
    always_comb begin
        ula_resultado = 16'h0000;
        ula_C         = 1'b0;
        case (ula_controle)
            5'b00000: {ula_C, ula_resultado} = {1'b0, ula_operandoA} + {1'b0, ula_operandoB};
            5'b10101: ula_resultado = ula_operandoA;
            5'b01000: {ula_C, ula_resultado} = {ula_operandoA, 1'b0};
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation for 80 cycles counted from the acceptance edge.
    // mid: cycle in which to pulse inicio again (0 = none)
    // fimp: pulse inicio in the first FIM cycle; b2b: pulse it in the cycle after
    // rst_at: cycle in which to assert rst (0 = none); snapshot taken one cycle later
    task automatic run(input logic [15:0] x, input logic [15:0] y,
                       input int mid, input bit fimp, input bit b2b, input int rst_at,
                       output int lat, output int lat2, output int n_pronto,
                       output int n_busy, output int n_add, output int n_pass,
                       output int n_shl, output logic [19:0] snap);
        lat = -1; lat2 = -1; n_pronto = 0; n_busy = 0;
        n_add = 0; n_pass = 0; n_shl = 0; snap = '1;
        @(posedge clk); #1;
        multiplicando = x; multiplicador = y; inicio = 1'b1;
        @(posedge clk); #1;
        inicio = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            #2;
            if (pronto) begin
                n_pronto++;
                if (lat < 0) lat = k;
                else if (lat2 < 0) lat2 = k;
            end
            if (ocupado) begin
                n_busy++;
                if (ula_controle == 5'b00000) n_add++;
                if (ula_controle == 5'b10101) n_pass++;
                if (ula_controle == 5'b01000) n_shl++;
            end
            if (rst_at > 0 && k == rst_at + 1)
                snap = {ocupado, pronto, produto, flag_overflow, flag_zero};
            inicio = (k == mid) || (fimp && pronto && k == lat) || (b2b && lat > 0 && k == lat + 1);
            rst    = (rst_at > 0 && k == rst_at);
            @(posedge clk); #1;
        end
        inicio = 1'b0;
        rst    = 1'b0;
        $display("[TB] x=0x%04h y=0x%04h produto=0x%04h ovf=%0b zero=%0b pronto_at=%0d",
                 x, y, produto, flag_overflow, flag_zero, lat);
    endtask

    int lat, lat2, np, nb, na, npa, ns;
    logic [19:0] snap;

    initial begin
        rst = 1'b1; inicio = 1'b0; multiplicando = 16'h0; multiplicador = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_produto", {16'h0, produto}, 32'h0);
        chk("rst_flags", {30'h0, flag_overflow, flag_zero}, 32'h0);
        chk("rst_status", {30'h0, ocupado, pronto}, 32'h0);
        chk("rst_controle", {27'h0, ula_controle}, 32'h10);
        rst = 1'b0;

        // 3 * 5
        run(16'd3, 16'd5, 0, 0, 0, 0, lat, lat2, np, nb, na, npa, ns, snap);
        chk("t1_latency", lat, 33);
        chk("t1_npronto", np, 1);
        chk("t1_busy", nb, 32);
        chk("t1_produto", {16'h0, produto}, 32'h000F);
        chk("t1_flags", {30'h0, flag_overflow, flag_zero}, 32'h0);

        // 0xFFFF * 0xFFFF = 0xFFFE0001
        run(16'hFFFF, 16'hFFFF, 0, 0, 0, 0, lat, lat2, np, nb, na, npa, ns, snap);
        chk("t2_latency", lat, 33);
        chk("t2_produto", {16'h0, produto}, 32'h0001);
        chk("t2_flags", {30'h0, flag_overflow, flag_zero}, 32'h2);

        // 0x0100 * 0x0100 = 0x10000
        run(16'h0100, 16'h0100, 0, 0, 0, 0, lat, lat2, np, nb, na, npa, ns, snap);
        chk("t3_produto", {16'h0, produto}, 32'h0000);
        chk("t3_flags", {30'h0, flag_overflow, flag_zero}, 32'h3);

        // 0x1234 * 0: no adds ever issued
        run(16'h1234, 16'h0000, 0, 0, 0, 0, lat, lat2, np, nb, na, npa, ns, snap);
        chk("t4_latency", lat, 33);
        chk("t4_produto", {16'h0, produto}, 32'h0000);
        chk("t4_flags", {30'h0, flag_overflow, flag_zero}, 32'h1);
        chk("t4_n_add", na, 0);
        chk("t4_n_pass", npa, 16);
        chk("t4_n_shl", ns, 16);

        // 7 * 9 with dropped inicio mid-run and in FIM, then back-to-back start
        run(16'd7, 16'd9, 10, 1, 1, 0, lat, lat2, np, nb, na, npa, ns, snap);
        chk("t5_latency", lat, 33);
        chk("t5_b2b_latency", lat2, 67);
        chk("t5_npronto", np, 2);
        chk("t5_busy", nb, 64);
        chk("t5_produto", {16'h0, produto}, 32'h003F);
        chk("t5_flags", {30'h0, flag_overflow, flag_zero}, 32'h0);

        // 2 * 2 aborted by reset at cycle 12
        run(16'd2, 16'd2, 0, 0, 0, 12, lat, lat2, np, nb, na, npa, ns, snap);
        chk("t6_snapshot", {12'h0, snap}, 32'h0);
        chk("t6_npronto", np, 0);
        chk("t6_busy", nb, 12);

        // Fresh run after the abort
        run(16'd4, 16'd4, 0, 0, 0, 0, lat, lat2, np, nb, na, npa, ns, snap);
        chk("t7_latency", lat, 33);
        chk("t7_produto", {16'h0, produto}, 32'h0010);
        chk("t7_flags", {30'h0, flag_overflow, flag_zero}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ula_mul_seq.md
Name: ula_mul_seq

Overview:
- Multi-cycle sequencer that computes an unsigned 16x16 shift-and-add multiplication by driving the shared ULA through its controle/operand ports.
- Sits between the control unit and the ULA, and owns the ULA inputs while busy.
- Produces the truncated 16-bit product plus overflow and zero flags, with a start/done handshake and fixed latency.

Parameters:
- bits_palavra, 16, word width of operands, product and ULA datapath.
- iteracoes, 16, number of shift-add iterations; must equal bits_palavra.

Ports:
- clk  input  1  system clock; everything is updated on the rising edge.
- rst  input  1  synchronous active-high reset.
- inicio  input  1  start request; sampled only in OCIOSO.
- multiplicando  input  bits_palavra  operand X; captured when inicio is accepted.
- multiplicador  input  bits_palavra  operand Y; captured when inicio is accepted.
- ocupado  output  1  high in SOMA and DESLOCA.
- pronto  output  1  high for exactly one cycle, in FIM.
- produto  output  bits_palavra  low word of X*Y; valid from pronto until the next accepted inicio.
- flag_overflow  output  1  set when the true product exceeds 2^bits_palavra-1.
- flag_zero  output  1  set when produto==0; valid with produto.
- ula_controle  output  5  opcode driven to the ULA.
- ula_operandoA  output  bits_palavra  ULA operand A.
- ula_operandoB  output  bits_palavra  ULA operand B.
- ula_resultado  input  bits_palavra  ULA result.
- ula_C  input  1  ULA carry flag.

Behaviour:
- Reset:
  - state=OCIOSO.
  - Internal acc, mcand, mult, cnt and sticky carry are cleared.
  - produto=0, flag_overflow=0, flag_zero=0, ocupado=0, pronto=0.
  - Reset takes priority over every other event, including mid-operation: the operation is aborted and no pronto is issued.
- ULA drive is combinational from state and registers:
  - OCIOSO/FIM: controle=10000, A=0, B=0.
  - SOMA: controle=00000 (A+B) if mult[0]=1, else 10101 (pass A); A=acc, B=mcand.
  - DESLOCA: controle=01000 (logical shift left A); A=mcand, B=0.
- OCIOSO:
  - On inicio=1: acc<=0, mcand<=multiplicando, mult<=multiplicador, cnt<=0, sticky<=0, then go to SOMA.
  - Otherwise stay in OCIOSO.
- SOMA:
  - acc<=ula_resultado.
  - If mult[0]=1 and ula_C=1, sticky<=1.
  - Next state is DESLOCA.
- DESLOCA:
  - mcand<=ula_resultado.
  - If ula_C=1 and (mult>>1)!=0, sticky<=1. A lost multiplicand bit only matters when higher multiplier bits are still pending.
  - mult<=mult>>1 (logical), cnt<=cnt+1.
  - If cnt==iteracoes-1, go to FIM; else go to SOMA.
- FIM:
  - pronto=1 for this cycle only.
  - produto, flag_zero and flag_overflow are registered on entry to FIM: produto=acc, flag_zero=(acc==0), flag_overflow=sticky.
  - Next state is always OCIOSO.
  - inicio asserted in FIM is ignored.
- Latency:
  - inicio accepted on edge of cycle T; SOMA/DESLOCA occupy cycles T+1..T+32; FIM and pronto fall in cycle T+33.
  - Latency is fixed regardless of operand values; there is no early exit.
- Handshake:
  - inicio asserted while ocupado=1 or pronto=1 is dropped, not queued.
  - Back-to-back operation: inicio in the cycle after FIM is accepted.
- Output stability: produto and flags hold their last value through OCIOSO and during the next operation, until the next FIM.
- Arithmetic: unsigned modulo 2^bits_palavra. The sign interpretation of the ULA is irrelevant; only resultado and C are consumed.

Test Plan:
- Reset, then X=3, Y=5, inicio pulse -> pronto exactly 33 cycles after acceptance; produto=0x000F, flag_overflow=0, flag_zero=0.
- X=0xFFFF, Y=0xFFFF -> produto=0x0001, flag_overflow=1, flag_zero=0.
- X=0x0100, Y=0x0100 -> produto=0x0000, flag_overflow=1, flag_zero=1.
- X=0x1234, Y=0 -> produto=0, flag_overflow=0, flag_zero=1. ula_controle alternates 10101/01000 for 32 cycles, never 00000.
- Start X=7, Y=9; pulse inicio again at cycle T+10 and in the FIM cycle -> single pronto at T+33, produto=0x003F. A further inicio the cycle after FIM starts a new run.
- Start X=2, Y=2; assert rst at T+12 -> next cycle state=OCIOSO, all outputs 0, no pronto. A fresh X=4, Y=4 run then returns produto=0x0010.
